// File: rtl/stream_delay_ctrl_pkg.sv
// Shared types and helpers for the fixed-latency stream delay controller.
package stream_delay_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Occupancy must be able to represent DEPTH itself, hence depth+1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_delay_ctrl_shift_reg.sv
// Enable-gated shift register; data stages carry no reset.
module shift_reg #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stg;

  always_ff @(posedge clk)
    if (en) stg <= {stg[DEPTH-2:0], d};

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/stream_delay_ctrl.sv
// Fixed DEPTH-cycle AXI-Stream delay line: per-stage valid tracking, whole-line
// stall on backpressure, occupancy, graceful drain and immediate flush.
module stream_delay_ctrl
  import stream_delay_ctrl_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int DWIDTH = 128,
  localparam int CW     = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              drain_req,
  input  logic              flush,
  output logic              drain_done,
  output logic [CW-1:0]     occupancy,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  vld;
  logic [CW-1:0]     occ;
  logic              stall, sr_en, in_hs, out_hs, drain_exit;

  assign stall  = vld[DEPTH-1] & ~m_axis_tready;
  assign sr_en  = ~stall;
  assign in_hs  = s_axis_tvalid & s_axis_tready;
  assign out_hs = vld[DEPTH-1] & m_axis_tready;

  assign m_axis_tvalid = vld[DEPTH-1];
  assign occupancy     = occ;

  shift_reg #(.W(DWIDTH + 1), .DEPTH(DEPTH)) u_sr (
    .clk (clk),
    .en  (sr_en),
    .d   ({s_axis_tlast, s_axis_tdata}),
    .q   ({m_axis_tlast, m_axis_tdata})
  );

  // Flush wins over everything: the beat on that edge is dropped, not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      occ <= '0;
    end else if (flush) begin
      vld <= '0;
      occ <= '0;
    end else begin
      if (sr_en) vld <= {vld[DEPTH-2:0], in_hs};
      case ({in_hs, out_hs})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign drain_exit = (occ == CW'(1) && out_hs) || (occ == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_FLUSH;
    else begin
      case (state_q)
        ST_RUN:   if (drain_req) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_exit) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = (state_q == ST_RUN) & ~stall & ~flush & ~drain_req;
    busy          = (state_q != ST_RUN);
    drain_done    = (state_q == ST_DRAIN) & ~flush & drain_exit;
  end

endmodule

// File: tb/tb_stream_delay_ctrl.sv
// Directed bench for stream_delay_ctrl at DEPTH=4, DWIDTH=8.
module tb_stream_delay_ctrl;

  localparam int DEPTH  = 4;
  localparam int DWIDTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DWIDTH-1:0] s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DWIDTH-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              drain_req = 1'b0;
  logic              flush = 1'b0;
  logic              drain_done;
  logic [2:0]        occ;
  logic              busy;

  stream_delay_ctrl #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .drain_req     (drain_req),
    .flush         (flush),
    .drain_done    (drain_done),
    .occupancy     (occ),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: records beats and the edge index each one crossed.
  int         cyc  = 0;
  int         dd_n = 0;
  int         dd_c = -1;
  logic [8:0] oq[$];
  int         ot[$];
  int         it[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        oq.push_back({m_tlast, m_tdata});
        ot.push_back(cyc);
      end
      if (s_tvalid && s_tready) it.push_back(cyc);
      if (drain_done) begin
        dd_n <= dd_n + 1;
        dd_c <= cyc;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic clr();
    oq.delete();
    ot.delete();
    it.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1'b1;
    tick();

    // 1: reset state
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_occ",    32'(occ),      32'd0);
    chk("rst_sready", 32'(s_tready), 32'd1);
    chk("rst_busy",   32'(busy),     32'd0);

    // 2: back-to-back stream, exact 4-cycle latency
    clr();
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), i == 8);
      chk("t2_occ", 32'(occ), (i < 4) ? 32'(i) : 32'd4);
    end
    repeat (6) tick();
    chk("t2_count", 32'(oq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < oq.size() && k < it.size()) begin
        chk("t2_data", 32'(oq[k][7:0]), 32'(k + 1));
        chk("t2_lat",  32'(ot[k] - it[k]), 32'd4);
      end
    if (oq.size() == 8) chk("t2_last", 32'(oq[7][8]), 32'd1);

    // 3: fill then backpressure for 10 cycles
    clr();
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    repeat (10) tick();
    s_tvalid = 1'b1;
    s_tdata  = 8'h77;
    #1;
    chk("t3_sready", 32'(s_tready), 32'd0);
    chk("t3_mvalid", 32'(m_tvalid), 32'd1);
    chk("t3_mdata",  32'(m_tdata),  32'h01);
    chk("t3_occ",    32'(occ),      32'd4);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    #1;
    chk("t3_sready_rel", 32'(s_tready), 32'd1);
    repeat (8) tick();
    chk("t3_count", 32'(oq.size()), 32'd4);
    chk("t3_in",    32'(it.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < oq.size()) chk("t3_data", 32'(oq[k][7:0]), 32'(k + 1));

    // 4: graceful drain of 3 beats
    clr();
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    drain_req = 1'b1;
    #1;
    chk("t4_sready_req", 32'(s_tready), 32'd0);
    tick();
    drain_req = 1'b0;
    #1;
    chk("t4_busy",   32'(busy),     32'd1);
    chk("t4_sready", 32'(s_tready), 32'd0);
    repeat (6) tick();
    chk("t4_busy_end", 32'(busy), 32'd0);
    chk("t4_occ_end",  32'(occ),  32'd0);
    chk("t4_dd_n",     32'(dd_n), 32'd1);
    chk("t4_count",    32'(oq.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < oq.size()) chk("t4_data", 32'(oq[k][7:0]), 32'(8'h11 + k));
    if (ot.size() == 3) chk("t4_dd_cyc", 32'(dd_c), 32'(ot[2]));
    chk("t4_sready_end", 32'(s_tready), 32'd1);

    // 5: flush with 3 beats in flight and one offered
    clr();
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h99;
    flush    = 1'b1;
    #1;
    chk("t5_sready_fl", 32'(s_tready), 32'd0);
    tick();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    #1;
    chk("t5_occ",    32'(occ),      32'd0);
    chk("t5_mvalid", 32'(m_tvalid), 32'd0);
    chk("t5_busy",   32'(busy),     32'd1);
    tick();
    chk("t5_busy_end", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("t5_count", 32'(oq.size()), 32'd0);

    // 5b: flush and drain_req together
    clr();
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    flush     = 1'b1;
    drain_req = 1'b1;
    tick();
    flush     = 1'b0;
    drain_req = 1'b0;
    #1;
    chk("t5b_busy", 32'(busy), 32'd1);
    chk("t5b_occ",  32'(occ),  32'd0);
    tick();
    chk("t5b_busy_end", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("t5b_count", 32'(oq.size()), 32'd0);
    chk("t5b_dd_n",  32'(dd_n),       32'd1);

    // 6: async reset mid-stream while stuck in DRAIN
    clr();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i), 1'b0);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    repeat (3) tick();
    #1;
    chk("t6_pre_busy",   32'(busy),     32'd1);
    chk("t6_pre_mvalid", 32'(m_tvalid), 32'd1);
    chk("t6_pre_occ",    32'(occ),      32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_mvalid", 32'(m_tvalid), 32'd0);
    chk("t6_occ",    32'(occ),      32'd0);
    chk("t6_busy",   32'(busy),     32'd0);
    chk("t6_sready", 32'(s_tready), 32'd1);
    #3;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    tick();
    clr();
    send(8'hAA, 1'b0);
    repeat (6) tick();
    chk("t6_count", 32'(oq.size()), 32'd1);
    if (oq.size() == 1 && it.size() == 1) begin
      chk("t6_data", 32'(oq[0][7:0]), 32'hAA);
      chk("t6_lat",  32'(ot[0] - it[0]), 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
